seg_scan_decoder: RTL and testbench



---
 rtl/seg_scan_decoder.sv | 136 +++++++++++++
 tb/tb_seg_scan_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - debounces a multiplexed active-low seven-segment bus and rebuilds the hex frame
// Optional: SEG_BLANK_ACCEPT_EN makes the all-off pattern a legal digit decoding to 0.
module seg_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3,
    localparam int EW           = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_en,
    input  logic                  ready,
    output logic [4*DIGITS-1:0]   value,
    output logic                  valid,
    output logic                  err,
    output logic [EW-1:0]         err_digit,
    output logic                  overrun
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [DIGITS+6:0]   samp;
    logic [CW-1:0]       cnt;
    logic [4*DIGITS-1:0] frame_buf;
    logic [DIGITS-1:0]   fill;
    logic [0:0]          state;

    logic [DIGITS+6:0]   in_vec;
    logic                same;
    logic                commit;
    logic                onehot;
    logic [DIGITS-1:0]   en_low;
    logic [EW-1:0]       idx;
    logic [4:0]          dec;
    logic                full;
    logic                accept;
    logic                do_write;
    logic [DIGITS-1:0]   fill_next;

    // Exact inverse of the encoder table; bit 4 flags a legal pattern.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40:   decode = 5'h10;
            7'h79:   decode = 5'h11;
            7'h24:   decode = 5'h12;
            7'h30:   decode = 5'h13;
            7'h19:   decode = 5'h14;
            7'h12:   decode = 5'h15;
            7'h02:   decode = 5'h16;
            7'h78:   decode = 5'h17;
            7'h00:   decode = 5'h18;
            7'h10:   decode = 5'h19;
            7'h08:   decode = 5'h1A;
            7'h03:   decode = 5'h1B;
            7'h46:   decode = 5'h1C;
            7'h21:   decode = 5'h1D;
            7'h06:   decode = 5'h1E;
            7'h0E:   decode = 5'h1F;
`ifdef SEG_BLANK_ACCEPT_EN
            7'h7F:   decode = 5'h10;
`endif
            default: decode = 5'h00;
        endcase
    endfunction

    assign in_vec = {dig_en, seg_in};
    assign same   = (in_vec == samp);
    // Counter saturates, so this matches only on the edge the run first reaches the threshold.
    assign commit = same && (cnt == CW'(STABLE_CYCLES - 1));
    assign en_low = ~dig_en;
    assign onehot = (en_low != '0) && ((en_low & (en_low - 1'b1)) == '0);
    assign dec    = decode(seg_in);
    assign full   = &fill;
    assign valid  = (state == PRESENT);
    assign accept = valid && ready;
    assign do_write = commit && onehot && dec[4];

    always_comb begin
        idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!dig_en[i]) idx = EW'(i);
        end
    end

    always_comb begin
        fill_next = full ? '0 : fill;
        if (do_write) fill_next[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp      <= '0;
            cnt       <= '0;
            frame_buf <= '0;
            fill      <= '0;
            state     <= COLLECT;
            value     <= '0;
            err       <= 1'b0;
            err_digit <= '0;
            overrun   <= 1'b0;
        end else begin
            samp <= in_vec;
            if (!same)
                cnt <= CW'(1);
            else if (cnt != CW'(STABLE_CYCLES))
                cnt <= cnt + 1'b1;

            fill <= fill_next;
            if (do_write)
                frame_buf[4*int'(idx) +: 4] <= dec[3:0];

            err <= 1'b0;
            if (commit && onehot && !dec[4]) begin
                err       <= 1'b1;
                err_digit <= idx;
            end

            // A completed frame either replaces the presented one or is dropped as overrun.
            if (full) begin
                if (!valid || ready) begin
                    value <= frame_buf;
                    state <= PRESENT;
                    if (accept) overrun <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (accept) begin
                state   <= COLLECT;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - randomized and directed bench for seg_scan_decoder against a behavioural model
module tb_seg_scan_decoder;

    localparam int D = 4;
    localparam int S = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = 7'h7F;
    logic [D-1:0] dig_en = 4'hF;
    logic        ready = 1'b1;
    logic [4*D-1:0] value;
    logic        valid;
    logic        err;
    logic [1:0]  err_digit;
    logic        overrun;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] enc [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // model state
    logic [10:0] m_prev;
    int          m_run;
    int          m_buf [D];
    bit          m_fill [D];
    logic [15:0] m_value;
    bit          m_valid, m_err, m_ovr;
    int          m_errd;

    seg_scan_decoder #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_en(dig_en), .ready(ready),
        .value(value), .valid(valid), .err(err), .err_digit(err_digit), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit lookup(input logic [6:0] s, output int nib);
        nib = 0;
        for (int n = 0; n < 16; n++) if (enc[n] == s) begin nib = n; return 1'b1; end
`ifdef SEG_BLANK_ACCEPT_EN
        if (s == 7'h7F) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic model_edge();
        logic [10:0] in;
        logic [15:0] old_val;
        bit was_full, cmt;
        int prev_run, zeros, idx, nib;
        if (!rst_n) begin
            m_prev = '0; m_run = 0; m_value = '0; m_valid = 0; m_err = 0; m_ovr = 0; m_errd = 0;
            for (int i = 0; i < D; i++) begin m_buf[i] = 0; m_fill[i] = 0; end
            return;
        end
        in = {dig_en, seg_in};
        prev_run = m_run;
        if (in == m_prev) m_run = (m_run < S) ? m_run + 1 : S;
        else m_run = 1;
        cmt = (in == m_prev) && (m_run == S) && (prev_run < S);
        m_prev = in;
        was_full = 1;
        old_val = '0;
        for (int i = 0; i < D; i++) begin
            if (!m_fill[i]) was_full = 0;
            old_val = old_val | (16'(m_buf[i]) << (4 * i));
        end
        m_err = 0;
        if (was_full) begin
            if (!m_valid || ready) begin
                if (m_valid) m_ovr = 0;
                m_value = old_val;
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
            for (int i = 0; i < D; i++) m_fill[i] = 0;
        end else if (m_valid && ready) begin
            m_valid = 0;
            m_ovr = 0;
        end
        if (cmt) begin
            zeros = 0; idx = 0;
            for (int i = 0; i < D; i++) if (!dig_en[i]) begin zeros++; idx = i; end
            if (zeros == 1) begin
                if (lookup(seg_in, nib)) begin
                    m_buf[idx] = nib;
                    m_fill[idx] = 1;
                end else begin
                    m_err = 1;
                    m_errd = idx;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("value", value, m_value);
        check("valid", valid, m_valid);
        check("err", err, m_err);
        check("err_digit", err_digit, m_errd[1:0]);
        check("overrun", overrun, m_ovr);
    endtask

    task automatic hold(input logic [3:0] en, input logic [6:0] s, input int n);
        dig_en = en;
        seg_in = s;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic frame(input logic [15:0] v, input int n);
        logic [15:0] t;
        t = v;
        for (int i = 0; i < D; i++) hold(~(4'b1 << i), enc[t[4*i +: 4]], n);
    endtask

    initial begin
        // reset with random inputs
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            seg_in = 7'($urandom); dig_en = 4'($urandom); ready = 1'($urandom);
            step();
        end
        check("rst_value", value, 16'h0);
        check("rst_valid", valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;

        // normal frame
        ready = 1'b1;
        hold(4'b1110, 7'b0110000, 4);
        hold(4'b1101, 7'b0011001, 4);
        hold(4'b1011, 7'b1000000, 4);
        hold(4'b0111, 7'b0001110, 4);
        check("frame_valid", valid, 1'b1);
        check("frame_value", value, 16'hF043);
        hold(4'b1111, 7'h7F, 1);
        check("frame_valid_drop", valid, 1'b0);

        // debounce: short holds never commit, multi-low enables ignored
        do_reset();
        frame(16'h9876, 2);
        hold(4'b1111, 7'h7F, 4);
        check("debounce_valid", valid, 1'b0);
        dig_en = 4'b1100; seg_in = enc[5];
        for (int k = 0; k < 5; k++) begin
            step();
            check("multi_low_err", err, 1'b0);
        end

        // invalid pattern on digit 2
        do_reset();
        hold(4'b1011, 7'b1111110, 3);
        check("inv_err", err, 1'b1);
        check("inv_err_digit", err_digit, 2'd2);
        hold(4'b1011, 7'b1111110, 1);
        check("inv_err_pulse", err, 1'b0);

        // blank pattern on digit 2
        hold(4'b1011, 7'h7F, 3);
`ifdef SEG_BLANK_ACCEPT_EN
        check("blank_err", err, 1'b0);
`else
        check("blank_err", err, 1'b1);
`endif

        // backpressure and overrun
        do_reset();
        ready = 1'b0;
        frame(16'h1234, 4);
        check("bp_first_value", value, 16'h1234);
        frame(16'h5678, 4);
        check("bp_value_held", value, 16'h1234);
        check("bp_valid", valid, 1'b1);
        check("bp_overrun", overrun, 1'b1);
        ready = 1'b1;
        hold(4'b1111, 7'h7F, 1);
        check("bp_release_valid", valid, 1'b0);
        check("bp_release_overrun", overrun, 1'b0);

        // reset mid-frame discards partial digits
        hold(4'b1110, enc[1], 3);
        hold(4'b1101, enc[2], 3);
        do_reset();
        frame(16'hABCD, 4);
        check("midrst_value", value, 16'hABCD);
        check("midrst_valid", valid, 1'b1);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            int sel, d;
            logic [6:0] s;
            logic [3:0] en;
            sel = $urandom_range(0, 19);
            d = $urandom_range(0, D - 1);
            en = ~(4'b1 << d);
            s = enc[$urandom_range(0, 15)];
            if (sel == 0) s = 7'($urandom);
            else if (sel == 1) s = 7'h7F;
            else if (sel == 2) en = 4'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            if (sel == 3 && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                hold(en, s, $urandom_range(1, 5));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
